exu_arb: RTL and testbench
==========================

EXU_ARB -- requirements
Module: exu_arb

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits.
REQ-002 clk_i  input  1  clock; all state changes on rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 reqN_valid_i  input  1  (N=0,1) requester N presents an ALU operation.
REQ-005 reqN_ready_o  output  1  (N=0,1) operation accepted this cycle.
REQ-006 reqN_pc_i, reqN_rs1_i, reqN_rs2_i, reqN_imm_i  input  XLEN each  (N=0,1) operand values.
REQ-007 reqN_a_sel_i [1:0], reqN_b_sel_i [1:0], reqN_comp_sel_i [2:0], reqN_op_0_i [0:0], reqN_op_1_i [2:0]  input  (N=0,1) ALU controls.
REQ-008 exu_pc_o, exu_rs1_o, exu_rs2_o, exu_imm_o  output  XLEN each  operands to the shared execute unit.
REQ-009 exu_a_sel_o 2, exu_b_sel_o 2, exu_comp_sel_o 3, exu_op_0_o 1, exu_op_1_o 3  output  controls to the execute unit.
REQ-010 exu_data_i  input  XLEN, exu_comp_i  input  1  execute-unit result and compare flag.
REQ-011 rspN_valid_o  output  1  (N=0,1) result for requester N is held.
REQ-012 rspN_ready_i  input  1  (N=0,1) requester N consumes the result.
REQ-013 rsp_data_o  output  XLEN, rsp_comp_o  output  1  result shared by both requesters; qualified by rspN_valid_o.

Function
REQ-014 FSM states IDLE, EXEC, RESP; exactly one active.
REQ-015 IDLE: if any reqN_valid_i, grant one requester, assert its reqN_ready_o combinationally, latch its operands/controls and the grant ID into registers, go to EXEC.
REQ-016 reqN_ready_o SHALL be 0 in EXEC and RESP, and never asserted for both requesters in the same cycle.
REQ-017 EXEC: exu_* outputs driven from the latched registers; at the end of the cycle latch exu_data_i/exu_comp_i into the result registers, go to RESP.
REQ-018 exu_* outputs hold their latched values in IDLE and RESP (no glitching to the live requester inputs).
REQ-019 RESP: rspN_valid_o=1 only for the granted N; stay until rspN_ready_i=1, then go to IDLE.
REQ-020 Latency: operation accepted in cycle t gives rspN_valid_o=1 in cycle t+2; next acceptance no earlier than the cycle after the response handshake.
REQ-021 rsp_data_o/rsp_comp_o stable throughout RESP; rspN_ready_i for the non-granted requester is ignored.
REQ-022 Requester inputs change only after acceptance; values presented while ready=0 are not sampled.
REQ-023 Last-grant register updated on every acceptance; reset value selects req1 as last granted, so req0 wins the first tie.

Reset
REQ-024 rst_i=1 at a clock edge: state=IDLE, all latched operand/control/result registers=0, last-grant=1; an in-flight operation is discarded with no response.
REQ-025 While rst_i=1: reqN_ready_o=0, rspN_valid_o=0, exu_* outputs=0, rsp_data_o=0, rsp_comp_o=0.

Configuration
REQ-026 Macro EXU_ARB_RR_EN defined: on simultaneous reqN_valid_i in IDLE, grant the requester not granted last (round-robin).
REQ-027 Macro EXU_ARB_RR_EN undefined: fixed priority, req0 always wins simultaneous requests; last-grant register still exists but does not affect arbitration.

Verification
REQ-028 req0 only: rs1=5, rs2=3, a_sel=RS1, b_sel=RS2, add op -> req0_ready_o=1 at t, exu_rs1_o=5 in t+1, rsp0_valid_o=1 with rsp_data_o=8 at t+2.
REQ-029 Both valid continuously for 4 ops with RR_EN -> grants 0,1,0,1; without RR_EN -> grants 0,0,0,0.
REQ-030 rsp1_ready_i held 0 for 5 cycles in RESP -> rsp1_valid_o and rsp_data_o stable, req0_ready_o=0 and req1_ready_o=0 throughout, rsp0_ready_i toggling has no effect.
REQ-031 Compare op, rs1=0xFFFFFFFF, rs2=1, signed less-than -> rsp_comp_o=1; unsigned less-than -> rsp_comp_o=0.
REQ-032 rst_i pulsed in EXEC -> next cycle state IDLE, no rspN_valid_o, all outputs 0; next request served normally with req0 winning a tie.

Source files
------------

// File: rtl/exu_arb.sv
// exu_arb: arbitrates two ALU requesters onto one shared execute unit (IDLE -> EXEC -> RESP).
// Define EXU_ARB_RR_EN for round-robin tie breaking; default is fixed priority with req0 first.
module exu_arb #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [XLEN-1:0] req0_pc_i,
  input  logic [XLEN-1:0] req0_rs1_i,
  input  logic [XLEN-1:0] req0_rs2_i,
  input  logic [XLEN-1:0] req0_imm_i,
  input  logic [1:0]      req0_a_sel_i,
  input  logic [1:0]      req0_b_sel_i,
  input  logic [2:0]      req0_comp_sel_i,
  input  logic [0:0]      req0_op_0_i,
  input  logic [2:0]      req0_op_1_i,
  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [XLEN-1:0] req1_pc_i,
  input  logic [XLEN-1:0] req1_rs1_i,
  input  logic [XLEN-1:0] req1_rs2_i,
  input  logic [XLEN-1:0] req1_imm_i,
  input  logic [1:0]      req1_a_sel_i,
  input  logic [1:0]      req1_b_sel_i,
  input  logic [2:0]      req1_comp_sel_i,
  input  logic [0:0]      req1_op_0_i,
  input  logic [2:0]      req1_op_1_i,
  output logic [XLEN-1:0] exu_pc_o,
  output logic [XLEN-1:0] exu_rs1_o,
  output logic [XLEN-1:0] exu_rs2_o,
  output logic [XLEN-1:0] exu_imm_o,
  output logic [1:0]      exu_a_sel_o,
  output logic [1:0]      exu_b_sel_o,
  output logic [2:0]      exu_comp_sel_o,
  output logic [0:0]      exu_op_0_o,
  output logic [2:0]      exu_op_1_o,
  input  logic [XLEN-1:0] exu_data_i,
  input  logic            exu_comp_i,
  output logic            rsp0_valid_o,
  input  logic            rsp0_ready_i,
  output logic            rsp1_valid_o,
  input  logic            rsp1_ready_i,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            rsp_comp_o
);

`ifdef EXU_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  localparam int OPW = 4 * XLEN + 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_gnt;
  logic            r_last;
  logic [OPW-1:0]  r_op;
  logic [XLEN-1:0] r_data;
  logic            r_comp;

  logic            w_any;
  logic            w_gnt_id;
  logic            w_accept;
  logic            w_rsp_hs;
  logic [OPW-1:0]  w_req0_op;
  logic [OPW-1:0]  w_req1_op;

  assign w_req0_op = {req0_pc_i, req0_rs1_i, req0_rs2_i, req0_imm_i, req0_a_sel_i,
                      req0_b_sel_i, req0_comp_sel_i, req0_op_0_i, req0_op_1_i};
  assign w_req1_op = {req1_pc_i, req1_rs1_i, req1_rs2_i, req1_imm_i, req1_a_sel_i,
                      req1_b_sel_i, req1_comp_sel_i, req1_op_0_i, req1_op_1_i};

  // Grant selection: ties go to the requester not served last only when round-robin is built in.
  always_comb begin
    w_any    = req0_valid_i | req1_valid_i;
    w_gnt_id = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      w_gnt_id = RR_EN ? ~r_last : 1'b0;
    end else if (req0_valid_i) begin
      w_gnt_id = 1'b0;
    end else begin
      w_gnt_id = 1'b1;
    end
    w_accept = (r_state == ST_IDLE) & w_any & ~rst_i;
    w_rsp_hs = (r_state == ST_RESP) & (r_gnt ? rsp1_ready_i : rsp0_ready_i);
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (w_rsp_hs) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture on acceptance, result capture at the end of EXEC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gnt  <= 1'b0;
      r_last <= 1'b1;
      r_op   <= {OPW{1'b0}};
      r_data <= {XLEN{1'b0}};
      r_comp <= 1'b0;
    end else begin
      if (w_accept) begin
        r_gnt  <= w_gnt_id;
        r_last <= w_gnt_id;
        r_op   <= w_gnt_id ? w_req1_op : w_req0_op;
      end
      if (r_state == ST_EXEC) begin
        r_data <= exu_data_i;
        r_comp <= exu_comp_i;
      end
    end
  end

  // Outputs are forced low while reset is held, even before the first clock edge.
  assign req0_ready_o = w_accept & ~w_gnt_id;
  assign req1_ready_o = w_accept & w_gnt_id;
  assign {exu_pc_o, exu_rs1_o, exu_rs2_o, exu_imm_o, exu_a_sel_o, exu_b_sel_o,
          exu_comp_sel_o, exu_op_0_o, exu_op_1_o} = rst_i ? {OPW{1'b0}} : r_op;
  assign rsp0_valid_o = (r_state == ST_RESP) & ~r_gnt & ~rst_i;
  assign rsp1_valid_o = (r_state == ST_RESP) & r_gnt & ~rst_i;
  assign rsp_data_o   = rst_i ? {XLEN{1'b0}} : r_data;
  assign rsp_comp_o   = rst_i ? 1'b0 : r_comp;

endmodule

// File: tb/tb_exu_arb.sv
// Self-checking bench for exu_arb: behavioural ALU environment plus a transaction-level grant/result model.
module tb_exu_arb;
  localparam int XLEN = 32;
`ifdef EXU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [2:0]  comp_sel;
    logic        op_0;
    logic [2:0]  op_1;
  } op_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic req0_valid_i, req0_ready_o, req1_valid_i, req1_ready_o;
  logic [31:0] req0_pc_i, req0_rs1_i, req0_rs2_i, req0_imm_i;
  logic [31:0] req1_pc_i, req1_rs1_i, req1_rs2_i, req1_imm_i;
  logic [1:0] req0_a_sel_i, req0_b_sel_i, req1_a_sel_i, req1_b_sel_i;
  logic [2:0] req0_comp_sel_i, req0_op_1_i, req1_comp_sel_i, req1_op_1_i;
  logic [0:0] req0_op_0_i, req1_op_0_i;
  logic [31:0] exu_pc_o, exu_rs1_o, exu_rs2_o, exu_imm_o, exu_data_i, rsp_data_o;
  logic [1:0] exu_a_sel_o, exu_b_sel_o;
  logic [2:0] exu_comp_sel_o, exu_op_1_o;
  logic [0:0] exu_op_0_o;
  logic exu_comp_i, rsp0_valid_o, rsp0_ready_i, rsp1_valid_o, rsp1_ready_i, rsp_comp_o;

  int vectors = 0;
  int miscompares = 0;
  op_t op [2];
  bit  vld [2];
  bit  pend [2];
  int  last_g;
  op_t w_exu_op;

  always #5 clk_i = ~clk_i;

  exu_arb #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_pc_i(req0_pc_i), .req0_rs1_i(req0_rs1_i), .req0_rs2_i(req0_rs2_i), .req0_imm_i(req0_imm_i),
    .req0_a_sel_i(req0_a_sel_i), .req0_b_sel_i(req0_b_sel_i), .req0_comp_sel_i(req0_comp_sel_i),
    .req0_op_0_i(req0_op_0_i), .req0_op_1_i(req0_op_1_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_pc_i(req1_pc_i), .req1_rs1_i(req1_rs1_i), .req1_rs2_i(req1_rs2_i), .req1_imm_i(req1_imm_i),
    .req1_a_sel_i(req1_a_sel_i), .req1_b_sel_i(req1_b_sel_i), .req1_comp_sel_i(req1_comp_sel_i),
    .req1_op_0_i(req1_op_0_i), .req1_op_1_i(req1_op_1_i),
    .exu_pc_o(exu_pc_o), .exu_rs1_o(exu_rs1_o), .exu_rs2_o(exu_rs2_o), .exu_imm_o(exu_imm_o),
    .exu_a_sel_o(exu_a_sel_o), .exu_b_sel_o(exu_b_sel_o), .exu_comp_sel_o(exu_comp_sel_o),
    .exu_op_0_o(exu_op_0_o), .exu_op_1_o(exu_op_1_o),
    .exu_data_i(exu_data_i), .exu_comp_i(exu_comp_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_comp_o(rsp_comp_o)
  );

  // Behavioural execute unit: returns {compare flag, data}.
  function automatic logic [32:0] alu(input op_t o);
    logic [31:0] a, b, d;
    logic c;
    case (o.a_sel)
      2'd0: a = o.rs1;
      2'd1: a = o.pc;
      2'd2: a = o.imm;
      default: a = 32'd0;
    endcase
    case (o.b_sel)
      2'd0: b = o.rs2;
      2'd1: b = o.imm;
      2'd2: b = 32'd4;
      default: b = 32'd0;
    endcase
    case (o.op_1)
      3'd0: d = o.op_0 ? a - b : a + b;
      3'd1: d = a ^ b;
      3'd2: d = a | b;
      3'd3: d = a & b;
      3'd4: d = a << b[4:0];
      3'd5: d = o.op_0 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: d = a;
      default: d = b;
    endcase
    case (o.comp_sel)
      3'd0: c = (a == b);
      3'd1: c = (a != b);
      3'd4: c = ($signed(a) < $signed(b));
      3'd5: c = ($signed(a) >= $signed(b));
      3'd6: c = (a < b);
      3'd7: c = (a >= b);
      default: c = 1'b0;
    endcase
    return {c, d};
  endfunction

  assign w_exu_op = {exu_pc_o, exu_rs1_o, exu_rs2_o, exu_imm_o, exu_a_sel_o, exu_b_sel_o,
                     exu_comp_sel_o, exu_op_0_o, exu_op_1_o};
  assign {exu_comp_i, exu_data_i} = alu(w_exu_op);

  function automatic op_t rand_op();
    op_t o;
    o.pc = $urandom; o.rs1 = $urandom; o.rs2 = $urandom; o.imm = $urandom;
    o.a_sel = 2'($urandom_range(0, 3)); o.b_sel = 2'($urandom_range(0, 3));
    o.comp_sel = 3'($urandom_range(0, 7)); o.op_0 = 1'($urandom_range(0, 1));
    o.op_1 = 3'($urandom_range(0, 7));
    return o;
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req0_valid_i = vld[0];
    {req0_pc_i, req0_rs1_i, req0_rs2_i, req0_imm_i, req0_a_sel_i, req0_b_sel_i,
     req0_comp_sel_i, req0_op_0_i, req0_op_1_i} = op[0];
    req1_valid_i = vld[1];
    {req1_pc_i, req1_rs1_i, req1_rs2_i, req1_imm_i, req1_a_sel_i, req1_b_sel_i,
     req1_comp_sel_i, req1_op_0_i, req1_op_1_i} = op[1];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy0"}, 160'(req0_ready_o), 160'(0));
    chk({tag, "_rdy1"}, 160'(req1_ready_o), 160'(0));
    chk({tag, "_rsp0"}, 160'(rsp0_valid_o), 160'(0));
    chk({tag, "_rsp1"}, 160'(rsp1_valid_o), 160'(0));
    chk({tag, "_exu"}, 160'(w_exu_op), 160'(0));
    chk({tag, "_data"}, 160'({rsp_comp_o, rsp_data_o}), 160'(0));
  endtask

  // One full transaction from IDLE back to IDLE; a waiting (pending) requester stays valid unchanged.
  task automatic do_op(input bit w0, input bit w1, input int hold, input bit rnd,
                       output int g, output logic [31:0] d, output logic c);
    int exp_g;
    op_t exp_op;
    logic [32:0] res;
    vld[0] = w0 | pend[0];
    vld[1] = w1 | pend[1];
    for (int n = 0; n < 2; n++)
      if (vld[n] && !pend[n] && rnd) op[n] = rand_op();
    drive();
    #1;
    exp_g = (vld[0] && vld[1]) ? (RR ? 1 - last_g : 0) : (vld[0] ? 0 : 1);
    chk("accept_rdy0", 160'(req0_ready_o), 160'(exp_g == 0));
    chk("accept_rdy1", 160'(req1_ready_o), 160'(exp_g == 1));
    g = req1_ready_o ? 1 : 0;
    exp_op = op[exp_g];
    res = alu(exp_op);
    last_g = exp_g;
    pend[exp_g] = 1'b0;
    pend[1 - exp_g] = vld[1 - exp_g];
    @(posedge clk_i); #1;
    vld[exp_g] = 1'b0;
    op[exp_g] = rand_op();
    drive();
    #1;
    chk("exec_exu", 160'(w_exu_op), 160'(exp_op));
    chk("exec_rdy", 160'({req0_ready_o, req1_ready_o}), 160'(0));
    chk("exec_rsp", 160'({rsp0_valid_o, rsp1_valid_o}), 160'(0));
    @(posedge clk_i); #1;
    d = 32'd0;
    c = 1'b0;
    for (int k = 0; k <= hold; k++) begin
      if (exp_g == 0) begin
        rsp0_ready_i = (k == hold);
        rsp1_ready_i = 1'(k & 1);
      end else begin
        rsp1_ready_i = (k == hold);
        rsp0_ready_i = 1'(k & 1);
      end
      #1;
      chk("resp_valid0", 160'(rsp0_valid_o), 160'(exp_g == 0));
      chk("resp_valid1", 160'(rsp1_valid_o), 160'(exp_g == 1));
      chk("resp_result", 160'({rsp_comp_o, rsp_data_o}), 160'(res));
      chk("resp_rdy", 160'({req0_ready_o, req1_ready_o}), 160'(0));
      chk("resp_exu_hold", 160'(w_exu_op), 160'(exp_op));
      d = rsp_data_o;
      c = rsp_comp_o;
      @(posedge clk_i); #1;
    end
    rsp0_ready_i = 1'b0;
    rsp1_ready_i = 1'b0;
    #1;
    chk("idle_rsp", 160'({rsp0_valid_o, rsp1_valid_o}), 160'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [31:0] d;
    logic c;
    rst_i = 1'b1;
    op[0] = '0; op[1] = '0;
    vld[0] = 1'b0; vld[1] = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    last_g = 1;
    rsp0_ready_i = 1'b0;
    rsp1_ready_i = 1'b0;
    drive();
    #1;
    chk_all_zero("rst_hold");
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk_all_zero("post_rst");

    // Basic add: 5 + 3.
    op[0] = '0;
    op[0].rs1 = 32'd5; op[0].rs2 = 32'd3;
    do_op(1'b1, 1'b0, 0, 1'b0, g, d, c);
    chk("add_grant", 160'(g), 160'(0));
    chk("add_data", 160'(d), 160'(32'd8));

    // Signed vs unsigned less-than with -1 and 1.
    op[0] = '0;
    op[0].rs1 = 32'hFFFF_FFFF; op[0].rs2 = 32'd1; op[0].comp_sel = 3'd4;
    do_op(1'b1, 1'b0, 1, 1'b0, g, d, c);
    chk("slt_comp", 160'(c), 160'(1));
    op[0] = '0;
    op[0].rs1 = 32'hFFFF_FFFF; op[0].rs2 = 32'd1; op[0].comp_sel = 3'd6;
    do_op(1'b1, 1'b0, 0, 1'b0, g, d, c);
    chk("sltu_comp", 160'(c), 160'(0));

    // req1 response held off for five cycles while rsp0_ready_i toggles.
    op[1] = rand_op();
    do_op(1'b0, 1'b1, 5, 1'b0, g, d, c);
    chk("hold_grant", 160'(g), 160'(1));

    // Both valid continuously for four operations.
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, 1'b1, i & 1, 1'b1, g, d, c);
      chk("tie_seq", 160'(g), 160'(RR ? (i % 2) : 0));
    end

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      bit w0, w1;
      w0 = 1'($urandom_range(0, 1));
      w1 = 1'($urandom_range(0, 1));
      if (!w0 && !w1 && !pend[0] && !pend[1]) w0 = 1'b1;
      do_op(w0, w1, $urandom_range(0, 3), 1'b1, g, d, c);
    end
    if (pend[0] || pend[1]) do_op(1'b0, 1'b0, 0, 1'b1, g, d, c);

    // Reset pulsed while an operation is in EXEC.
    op[0] = rand_op();
    vld[0] = 1'b1; vld[1] = 1'b0;
    drive();
    #1;
    chk("pre_rst_rdy0", 160'(req0_ready_o), 160'(1));
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    vld[0] = 1'b0; vld[1] = 1'b1;
    op[1] = rand_op();
    drive();
    #1;
    chk_all_zero("rst_exec");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    vld[1] = 1'b0;
    drive();
    #1;
    chk_all_zero("rst_after");
    last_g = 1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    @(posedge clk_i); #1;
    chk("rst_no_rsp", 160'({rsp0_valid_o, rsp1_valid_o}), 160'(0));
    do_op(1'b1, 1'b1, 0, 1'b1, g, d, c);
    chk("rst_tie_grant", 160'(g), 160'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
